parity_frame_tx: RTL

// - Upstream feeder for the serial parity-checker FSM.
// - Accepts a parallel data word on a valid/ready handshake and serializes it LSB-first onto one bit line.
// - Appends one parity bit per frame. With default (even) parity, every frame carries an even number of 1s,
//   so a downstream checker reset at frame_start reads 0 after the parity cycle.

---
 rtl/parity_frame_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/parity_frame_tx.sv
// parity_frame_tx: serializes DATA_W-bit words LSB-first, one parity bit per frame.
// Even parity by default; define ODD_PARITY_EN for odd parity.
module parity_frame_tx #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              sout_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic [CNT_W-1:0]  tx_count
);

    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              par_q, par_d;
    logic [CNT_W-1:0]  tx_count_q, tx_count_d;

    logic              din_ready_q, din_ready_d;
    logic              sout_q, sout_d;
    logic              sout_valid_q, sout_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_end_q, frame_end_d;

    logic              accept;
    logic              parity_bit;

    assign accept = din_valid && din_ready_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        tx_count_d = tx_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_DATA;
                    shreg_d   = din;
                    bit_cnt_d = '0;
                    par_d     = 1'b0;
                end
            end
            S_DATA: begin
                par_d     = par_q ^ shreg_q[0];
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                tx_count_d = tx_count_q + CNT_W'(1);
                if (accept) begin
                    state_d   = S_DATA;
                    shreg_d   = din;
                    bit_cnt_d = '0;
                    par_d     = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef ODD_PARITY_EN
    assign parity_bit = ~par_d;
`else
    assign parity_bit = par_d;
`endif

    // Outputs are precomputed from next state so every port comes straight from a flop.
    always_comb begin
        din_ready_d   = (state_d == S_IDLE) || (state_d == S_PARITY);
        sout_valid_d  = (state_d != S_IDLE);
        frame_start_d = (state_d == S_DATA) && (bit_cnt_d == '0);
        frame_end_d   = (state_d == S_PARITY);
        sout_d        = 1'b0;
        if (state_d == S_DATA) begin
            sout_d = shreg_d[0];
        end else if (state_d == S_PARITY) begin
            sout_d = parity_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            par_q         <= 1'b0;
            tx_count_q    <= '0;
            din_ready_q   <= 1'b1;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            par_q         <= par_d;
            tx_count_q    <= tx_count_d;
            din_ready_q   <= din_ready_d;
            sout_q        <= sout_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign din_ready   = din_ready_q;
    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign tx_count    = tx_count_q;

endmodule
